// File: rtl/sync_pkg.sv
// sync_pkg: shared types and helpers for sync_debounce_edge
package sync_pkg;
  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;
  function automatic int filt_cnt_w(int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sync_debounce_ch.sv
// sync_debounce_ch: one channel of synchroniser, stability filter, edge pulses and sticky flag
//   clk, rst_n         clock, async active-low reset
//   din                asynchronous level input
//   clr                synchronous clear of event_sticky
//   dout               synchronised, filtered level
//   rise, fall         one-cycle pulses in the first cycle dout shows a new value
//   event_sticky       set by rise/fall, held until clr
module sync_debounce_ch
  import sync_pkg::*;
#(
  parameter int   N_STAGE       = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RST_BIT       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic clr,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic event_sticky
);
  localparam int CW = filt_cnt_w(FILTER_CYCLES);
  localparam logic [CW-1:0] TC = CW'(FILTER_CYCLES - 1);
  if (N_STAGE < 2) begin : g_bad_n_stage
    $error("sync_debounce_ch: N_STAGE must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("sync_debounce_ch: FILTER_CYCLES must be >= 1");
  end
  (* ASYNC_REG = "TRUE" *) logic [N_STAGE-1:0] sr;
  logic [CW-1:0] cnt;
  edge_t ed;
  logic s, upd;
  assign s    = sr[N_STAGE-1];
  // any cycle with s == dout clears cnt, so reaching TC means FILTER_CYCLES consecutive differing cycles
  assign upd  = (s != dout) && (cnt == TC);
  assign rise = ed.rise;
  assign fall = ed.fall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr           <= {N_STAGE{RST_BIT}};
      dout         <= RST_BIT;
      cnt          <= '0;
      ed           <= '0;
      event_sticky <= 1'b0;
    end else begin
      sr           <= {sr[N_STAGE-2:0], din};
      dout         <= upd ? s : dout;
      cnt          <= (s == dout || upd) ? '0 : cnt + 1'b1;
      ed           <= '{rise: upd & s, fall: upd & ~s};
      // set term is the registered pulse, so a coincident clr loses
      event_sticky <= (event_sticky & ~clr) | ed.rise | ed.fall;
    end
endmodule

// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: multi-channel synchroniser + debounce filter with edge pulses and sticky flags
//   clk, rst_n         clock, async active-low reset
//   din[SIZE]          asynchronous level inputs
//   clr[SIZE]          per-channel synchronous clear of event_sticky
//   dout[SIZE]         synchronised, filtered levels
//   rise/fall[SIZE]    one-cycle filtered edge pulses
//   event_sticky[SIZE] per-channel sticky edge flag
module sync_debounce_edge
  import sync_pkg::*;
#(
  parameter int              SIZE          = 1,
  parameter int              N_STAGE       = 2,
  parameter int              FILTER_CYCLES = 4,
  parameter logic [SIZE-1:0] RST_VAL       = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] din,
  input  logic [SIZE-1:0] clr,
  output logic [SIZE-1:0] dout,
  output logic [SIZE-1:0] rise,
  output logic [SIZE-1:0] fall,
  output logic [SIZE-1:0] event_sticky
);
  for (genvar i = 0; i < SIZE; i++) begin : g_ch
    sync_debounce_ch #(
      .N_STAGE      (N_STAGE),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RST_BIT      (RST_VAL[i])
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din[i]),
      .clr         (clr[i]),
      .dout        (dout[i]),
      .rise        (rise[i]),
      .fall        (fall[i]),
      .event_sticky(event_sticky[i])
    );
  end
endmodule

// File: doc/sync_debounce_edge.md
# sync_debounce_edge

Multi-channel, single-clock input conditioner for asynchronous level signals: pins, status lines from unrelated logic, or slow control bits. Each bit is synchronised through an N-stage metastability chain, then passed through a stability filter that rejects pulses shorter than a programmable number of cycles. Per-channel rise/fall pulses and a sticky event flag with clear are generated from the filtered level. Channels are independent; no relationship between bits is guaranteed.

## Interface
- SIZE, 1: number of independent channels (≥1)
- N_STAGE, 2: synchroniser flop stages per channel (≥2)
- FILTER_CYCLES, 4: consecutive cycles a new synchronised value must hold before `dout` adopts it (≥1; 1 = no filtering, register only)
- RST_VAL, '0: SIZE-bit reset level for the sync chain and `dout`
- clk  input  1  sole clock
- rst_n  input  1  asynchronous, active-low reset
- din  input  SIZE  asynchronous level inputs
- clr  input  SIZE  synchronous per-channel clear of `event_sticky`
- dout  output  SIZE  synchronised, filtered level
- rise  output  SIZE  one-cycle pulse, filtered 0→1 transition
- fall  output  SIZE  one-cycle pulse, filtered 1→0 transition
- event_sticky  output  SIZE  set by any rise/fall, held until cleared

## Operation
- Sync chain: `din[i]` → N_STAGE flops, all marked ASYNC_REG, last stage is `s[i]`. No input register.
- Filter per channel: counter `cnt`, width clog2(FILTER_CYCLES+1).
  - `s == dout`: `cnt` ← 0.
  - `s != dout` and `cnt < FILTER_CYCLES-1`: `cnt` ← `cnt`+1.
  - `s != dout` and `cnt == FILTER_CYCLES-1`: `dout` ← `s`, `cnt` ← 0.
  - Any cycle with `s == dout` before terminal count discards progress; a glitch of FILTER_CYCLES-1 or fewer cycles at `s` never reaches `dout`.
- Edges: `rise` ← (update && `s`==1), `fall` ← (update && `s`==0); registered, so each is high exactly in the first cycle `dout` shows the new value.
- Sticky: `event_sticky` ← (`event_sticky` & ~`clr`) | `rise` | `fall`. The set term is the registered edge pulse, so the flag rises one cycle after `dout` changes. When a set and `clr` coincide, set wins and the flag stays 1.
- Reset (rst_n low, asynchronous): sync flops and `dout` = RST_VAL; `cnt`, `rise`, `fall`, `event_sticky` = 0. Released synchronously to clk by the system reset synchroniser.
- After reset release with `din` ≠ RST_VAL: the channel transitions normally after full latency and emits the corresponding edge pulse. This is intended behaviour.
- Reset asserted mid-filter: in-progress count is discarded; no partial edge is emitted.

## Timing
- Latency, stable `din` change → `dout`/edge pulse: N_STAGE + FILTER_CYCLES clk edges (±1 for asynchronous sampling uncertainty).
- Defaults: 6 cycles. FILTER_CYCLES=1: N_STAGE+1 cycles.
- Minimum accepted pulse width at `s`: FILTER_CYCLES cycles. Minimum spacing between two edges on `dout`: FILTER_CYCLES cycles.
- `rise` and `fall` are never both high on one channel in one cycle.
- `clr` takes effect on the next edge; `event_sticky` reads 0 the cycle after `clr` unless a set coincides.

## Structure
- Package `sync_pkg`:
  - function `filt_cnt_w(int n)` returning clog2(n+1), minimum 1
  - typedef `edge_t` as a struct of {rise, fall}
- Sub-module `sync_debounce_ch`: one channel (sync chain, filter counter, edge and sticky logic), parameters N_STAGE, FILTER_CYCLES, RST_BIT.
- Top level: generate loop over SIZE only.
- Parameter legality (N_STAGE ≥ 2, FILTER_CYCLES ≥ 1) checked with elaboration-time assertions.

## Test plan
- Reset, defaults, SIZE=4, RST_VAL=4'b0000, `din`=4'b0000: `dout`=0, no pulses. Drive `din[2]`=1 and hold: `dout[2]`=1 and `rise[2]` high for one cycle, exactly 6 cycles after the sampling edge. `event_sticky[2]`=1 from the next cycle.
- Glitch rejection, FILTER_CYCLES=4: 3-cycle high pulse on `din[0]` → `dout[0]` stays 0, no `rise`. 4-cycle pulse → `rise[0]` then `fall[0]`, spaced 4 cycles.
- Chatter: `din[1]` toggles 1,1,0,1,1,1,1 → counter restarts at the 0; `rise[1]` appears 4 cycles after the last restart, not earlier.
- Sticky clear: `event_sticky[3]`=1. Pulse `clr[3]` → 0 next cycle. Pulse `clr[3]` in the same cycle as a `rise[3]`/`fall[3]` → stays 1.
- Reset mid-count: `din[0]`=1 and `cnt`=2, assert `rst_n`=0 → all outputs at reset values immediately. Release with `din[0]` still 1 → `rise[0]` after full latency.
- RST_VAL=4'b1111, `din`=0 held through reset → each channel emits exactly one `fall` at N_STAGE+FILTER_CYCLES cycles after release.
